mips_branch_predict_unit: RTL and testbench
===========================================

# mips_branch_predict_unit

Parametrised branch resolution and prediction unit for the MIPS pipeline. It generalises the single-type (BEQ) equality resolver to six conditional branch types and adds a direct-mapped branch history table (BHT) of saturating counters. The BHT provides a taken/not-taken prediction to IF and is trained when the branch resolves in ID. The unit flags mispredictions with a flush request and keeps saturating performance counters. It sits between the register file read ports and the fetch PC mux.

## Interface
Parameters:
- DATA_W, 32, datapath and PC width
- BHT_DEPTH, 64, number of BHT entries; power of two, ≥2
- CNT_W, 2, saturating counter width; ≥1
- CNT_INIT, 1, counter reset value, weakly not-taken for CNT_W=2; must be < 2^CNT_W
- PERF_W, 16, performance counter width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- if_pc  in  DATA_W  PC of the instruction being fetched
- pred_taken  out  1  prediction for if_pc; combinational
- id_valid  in  1  ID stage holds a valid instruction
- id_stall  in  1  ID held this cycle; suppresses resolution side effects
- id_pc  in  DATA_W  PC of the ID instruction
- id_pred_taken  in  1  pred_taken value piped down with the ID instruction
- id_is_branch  in  1  ID instruction is a conditional branch
- id_br_type  in  3  0=EQ, 1=NE, 2=LEZ, 3=GTZ, 4=LTZ, 5=GEZ; 6 and 7 are reserved
- read_data_1  in  DATA_W  rs operand
- read_data_2  in  DATA_W  rt operand
- branch_taken  out  1  resolved branch outcome; combinational
- flush_branch  out  1  misprediction; flush IF and redirect fetch
- redirect_taken  out  1  when flush_branch=1: 1 = fetch branch target, 0 = fetch id_pc+4
- perf_branches  out  PERF_W  resolved branch count
- perf_mispredicts  out  PERF_W  misprediction count

## Operation
- IDX_W = log2(BHT_DEPTH). Index = pc[IDX_W+1:2]. Upper PC bits are ignored, so aliasing is allowed.
- pred_taken = MSB of BHT[if_pc index].
- Condition evaluation. LEZ, GTZ, LTZ and GEZ compare read_data_1 against zero as a signed value; read_data_2 is ignored for these types.
  - EQ: rs==rt
  - NE: rs!=rt
  - LEZ: rs≤0
  - GTZ: rs>0
  - LTZ: rs<0
  - GEZ: rs≥0
  - Reserved types evaluate to not-taken.
- branch_taken = id_valid & id_is_branch & cond.
- resolve = id_valid & ~id_stall.
- flush_branch = resolve & (id_is_branch ? (cond != id_pred_taken) : id_pred_taken). A predicted-taken non-branch (alias) flushes to the fall-through path.
- redirect_taken = branch_taken.
- BHT update happens only on resolve & id_is_branch, at index id_pc[IDX_W+1:2]:
  - taken: counter +1, saturating at 2^CNT_W−1
  - not-taken: counter −1, saturating at 0
  - Non-branches never write the BHT.
- Performance counters:
  - perf_branches increments on resolve & id_is_branch.
  - perf_mispredicts increments on flush_branch, including the alias case.
  - Both saturate at all-ones; no wrap.

## Timing
- Reset (sync, rst=1 at a clk edge):
  - every BHT entry ← CNT_INIT
  - perf_branches = perf_mispredicts = 0
- After reset, pred_taken = MSB(CNT_INIT), i.e. 0 for the defaults.
- Combinational outputs (pred_taken, branch_taken, flush_branch, redirect_taken) are forced to 0 while rst=1.
- pred_taken, branch_taken, flush_branch and redirect_taken have zero-cycle latency from their inputs.
- BHT write becomes visible at the next clk edge.
- Same-cycle read and write to the same index: pred_taken reflects the old value. There is no bypass.
- Perf counters update at the clk edge following the qualifying cycle.
- While id_stall=1: no BHT write, no counter increment, flush_branch=0. branch_taken still reflects the current operands.
- Reset asserted mid-operation discards the in-flight update. The table and counters hold reset values from the next edge until rst deasserts.

## Test plan
- Reset, then if_pc=0x0040_0000 → pred_taken=0, perf_branches=0, perf_mispredicts=0.
- EQ branch, id_pc=0x0040_0010, rs=rt=5, id_pred_taken=0 → branch_taken=1, flush_branch=1, redirect_taken=1. Next cycle, if_pc=0x0040_0010 → pred_taken=1 (counter 1→2), perf_mispredicts=1.
- Resolve the same PC taken three more times → counter saturates at 3. Then one not-taken → counter 2, pred_taken stays 1.
- Each signed type with rs=0xFFFF_FFFF (−1):
  - LEZ=1, GTZ=0, LTZ=1, GEZ=0
  - NE with rs=1, rt=2 → 1
  - type 6 → branch_taken=0
- Non-branch with id_pred_taken=1 → flush_branch=1, redirect_taken=0, no BHT change, perf_branches unchanged.
- id_stall=1 held 3 cycles on a mispredicted branch → no flush and no counts. Release stall → exactly one update and one flush. Separately, force PERF_W=2 with 5 branches → perf_branches=3.

Source files
------------

// File: rtl/mips_branch_predict_unit.sv
// Branch resolution for six conditional branch types plus a direct-mapped BHT of
// saturating counters that predicts for IF and trains on resolution in ID.
module mips_branch_predict_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int CNT_INIT  = 1,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_pc,
    output logic              pred_taken,
    input  logic              id_valid,
    input  logic              id_stall,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              id_pred_taken,
    input  logic              id_is_branch,
    input  logic [2:0]        id_br_type,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    output logic              branch_taken,
    output logic              flush_branch,
    output logic              redirect_taken,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LEZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LTZ = 3'd4,
        BR_GEZ = 3'd5
    } br_type_e;

    logic [CNT_W-1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;
    logic [CNT_W-1:0] bht_cur;
    logic [CNT_W-1:0] bht_next;
    logic             cond;
    logic             rs_neg;
    logic             rs_zero;
    logic             resolve;
    logic             bht_we;
    logic             unused_pc_bits;

    // Word-aligned PCs: bits [1:0] and everything above the index alias freely.
    assign if_idx  = if_pc[IDX_W+1:2];
    assign id_idx  = id_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[DATA_W-1:IDX_W+2], if_pc[1:0],
                              id_pc[DATA_W-1:IDX_W+2], id_pc[1:0]};

    assign rs_neg  = read_data_1[DATA_W-1];
    assign rs_zero = (read_data_1 == '0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cond = 1'b0;
        case (br_type_e'(id_br_type))
            BR_EQ:   cond = (read_data_1 == read_data_2);
            BR_NE:   cond = (read_data_1 != read_data_2);
            BR_LEZ:  cond = rs_neg | rs_zero;
            BR_GTZ:  cond = ~rs_neg & ~rs_zero;
            BR_LTZ:  cond = rs_neg;
            BR_GEZ:  cond = ~rs_neg;
            default: cond = 1'b0;
        endcase
    end

    assign resolve        = id_valid & ~id_stall & ~rst;
    assign bht_we         = resolve & id_is_branch;
    assign pred_taken     = ~rst & bht[if_idx][CNT_W-1];
    assign branch_taken   = ~rst & id_valid & id_is_branch & cond;
    assign redirect_taken = branch_taken;
    // A predicted-taken non-branch is an alias hit and must return to the fall-through path.
    assign flush_branch   = resolve & (id_is_branch ? (cond != id_pred_taken) : id_pred_taken);

    assign bht_cur = bht[id_idx];

    always_comb begin
        bht_next = bht_cur;
        if (cond) begin
            if (bht_cur != CNT_MAX) bht_next = bht_cur + CNT_W'(1);
        end else begin
            if (bht_cur != '0) bht_next = bht_cur - CNT_W'(1);
        end
    end

    // NOTE: the table is reset entry by entry, so it builds as flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_RST;
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            // NOTE: non-blocking updates keep the same-cycle IF read on the old counter value.
            if (bht_we) bht[id_idx] <= bht_next;
            if (bht_we && perf_branches != PERF_MAX)
                perf_branches <= perf_branches + PERF_W'(1);
            if (flush_branch && perf_mispredicts != PERF_MAX)
                perf_mispredicts <= perf_mispredicts + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_branch_predict_unit.sv
// Random and directed stimulus against an array-based model of the predictor and
// resolver; a second instance with PERF_W=2 checks perf counter saturation.
module tb_mips_branch_predict_unit;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        id_valid = 1'b0;
    logic        id_stall = 1'b0;
    logic [31:0] id_pc = '0;
    logic        id_pred_taken = 1'b0;
    logic        id_is_branch = 1'b0;
    logic [2:0]  id_br_type = '0;
    logic [31:0] read_data_1 = '0;
    logic [31:0] read_data_2 = '0;

    logic        pred_taken, branch_taken, flush_branch, redirect_taken;
    logic [15:0] perf_branches, perf_mispredicts;
    logic        pred_taken_2, branch_taken_2, flush_branch_2, redirect_taken_2;
    logic [1:0]  perf_branches_2, perf_mispredicts_2;

    int total = 0;
    int bad   = 0;

    int m_bht [DEPTH];
    int m_br, m_mis, m_br2, m_mis2;

    always #5 clk = ~clk;

    mips_branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
        .id_pred_taken(id_pred_taken), .id_is_branch(id_is_branch),
        .id_br_type(id_br_type), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .branch_taken(branch_taken), .flush_branch(flush_branch),
        .redirect_taken(redirect_taken), .perf_branches(perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    mips_branch_predict_unit #(.PERF_W(2)) dut_p2 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken_2),
        .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
        .id_pred_taken(id_pred_taken), .id_is_branch(id_is_branch),
        .id_br_type(id_br_type), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .branch_taken(branch_taken_2), .flush_branch(flush_branch_2),
        .redirect_taken(redirect_taken_2), .perf_branches(perf_branches_2),
        .perf_mispredicts(perf_mispredicts_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit m_cond(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (ty)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
    endtask

    // One cycle: drive, check combinational outputs mid-cycle, clock, update model, check counters.
    task automatic step(input logic [31:0] ipc, input bit v, input bit st, input logic [31:0] dpc,
                        input bit pt, input bit isb, input logic [2:0] ty,
                        input logic [31:0] a, input logic [31:0] b);
        bit c, e_pred, e_bt, e_flush, res;
        if_pc = ipc; id_valid = v; id_stall = st; id_pc = dpc; id_pred_taken = pt;
        id_is_branch = isb; id_br_type = ty; read_data_1 = a; read_data_2 = b;
        #2;
        c       = m_cond(ty, a, b);
        res     = v && !st && !rst;
        e_pred  = !rst && (m_bht[idx_of(ipc)] >= 2);
        e_bt    = !rst && v && isb && c;
        e_flush = res && (isb ? (c != pt) : pt);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, e_pred});
        check("branch_taken", {31'b0, branch_taken}, {31'b0, e_bt});
        check("flush_branch", {31'b0, flush_branch}, {31'b0, e_flush});
        check("redirect_taken", {31'b0, redirect_taken}, {31'b0, e_bt});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (res && isb) begin
                if (c) m_bht[idx_of(dpc)] = sat_inc(m_bht[idx_of(dpc)], 3);
                else if (m_bht[idx_of(dpc)] > 0) m_bht[idx_of(dpc)]--;
                m_br  = sat_inc(m_br, 65535);
                m_br2 = sat_inc(m_br2, 3);
            end
            if (e_flush) begin
                m_mis  = sat_inc(m_mis, 65535);
                m_mis2 = sat_inc(m_mis2, 3);
            end
        end
        #1;
        check("perf_branches", 32'(perf_branches), m_br);
        check("perf_mispredicts", 32'(perf_mispredicts), m_mis);
        check("perf_branches_w2", 32'(perf_branches_2), m_br2);
        check("perf_mispredicts_w2", 32'(perf_mispredicts_2), m_mis2);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'h0000_0005;
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] PC0 = 32'h0040_0000;
    localparam logic [31:0] PCB = 32'h0040_0010;
    localparam logic [31:0] M1  = 32'hFFFF_FFFF;

    initial begin
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        step(PC0, 1, 0, PCB, 1, 1, 3'd0, 5, 5);
        step(PC0, 1, 0, PCB, 1, 1, 3'd0, 5, 5);
        rst = 1'b0;

        // Reset state.
        step(PC0, 0, 0, PC0, 0, 0, 3'd0, 0, 0);
        check("reset_pred", {31'b0, pred_taken}, 32'd0);
        check("reset_perf_br", 32'(perf_branches), 32'd0);

        // EQ taken while predicted not-taken: flush and train 1 -> 2.
        step(PC0, 1, 0, PCB, 0, 1, 3'd0, 5, 5);
        if_pc = PCB; #1;
        check("trained_pred", {31'b0, pred_taken}, 32'd1);
        check("first_mispredict", 32'(perf_mispredicts), 32'd1);
        for (int i = 0; i < 3; i++) step(PCB, 1, 0, PCB, 1, 1, 3'd0, 7, 7);
        step(PCB, 1, 0, PCB, 1, 1, 3'd0, 7, 8);
        step(PCB, 0, 0, PCB, 0, 0, 3'd0, 0, 0);

        // Signed-zero types with rs = -1, NE, reserved.
        step(PC0, 1, 0, PC0 + 32'h20, 0, 1, 3'd2, M1, 0);
        step(PC0, 1, 0, PC0 + 32'h20, 0, 1, 3'd3, M1, 0);
        step(PC0, 1, 0, PC0 + 32'h20, 0, 1, 3'd4, M1, 0);
        step(PC0, 1, 0, PC0 + 32'h20, 0, 1, 3'd5, M1, 0);
        step(PC0, 1, 0, PC0 + 32'h24, 0, 1, 3'd1, 1, 2);
        step(PC0, 1, 0, PC0 + 32'h28, 1, 1, 3'd6, 3, 3);
        step(PC0, 1, 0, PC0 + 32'h28, 1, 1, 3'd7, 0, 0);

        // Predicted-taken non-branch alias.
        step(PCB, 1, 0, PCB, 1, 0, 3'd0, 5, 5);

        // Stalled mispredicted branch, then release.
        for (int i = 0; i < 3; i++) step(PC0, 1, 1, PC0 + 32'h30, 1, 1, 3'd0, 1, 2);
        step(PC0, 1, 0, PC0 + 32'h30, 1, 1, 3'd0, 1, 2);
        check("perf_w2_saturated", 32'(perf_branches_2), 32'd3);

        // Reset in the middle of a resolving branch discards it.
        rst = 1'b1;
        step(PCB, 1, 0, PCB, 0, 1, 3'd0, 4, 4);
        rst = 1'b0;
        step(PCB, 0, 0, PCB, 0, 0, 3'd0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ipc, dpc;
            ipc = PC0 + ($urandom_range(0, 15) << 2);
            dpc = PC0 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) dpc = dpc + ($urandom_range(1, 255) << 8);
            rst = ($urandom_range(0, 199) == 0);
            step(ipc, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20, dpc,
                 1'($urandom), $urandom_range(0, 99) < 75, 3'($urandom),
                 pick_operand(), pick_operand());
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
